// File: rtl/cdb_broadcast.sv
// -----------------------------------------------------------------------------
// cdb_broadcast
//
// Completion side of the Common Data Bus. Each functional unit owns one
// holding slot. A round-robin arbiter picks up to WAYS held slots per cycle
// and broadcasts them on registered CDB lanes. Lanes fill from lane 0
// upward. A squash or reset discards every held and in-flight result.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   squash               mispredict nuke: drop held, in-flight and offered results
//   fu_valid/fu_*        per-FU result offer (ROB index, PRN, value, branch info)
//   fu_ready             per-FU combinational accept (slot free or draining now)
//   cdb_valid/cdb_*      per-lane registered broadcast; invalid lanes carry zeros
//   pending              number of occupied holding slots
// -----------------------------------------------------------------------------
module cdb_broadcast #(
   parameter int NUM_FU      = 4,
   parameter int WAYS        = 2,
   parameter int ROB_ENTRIES = 32,
   parameter int PRF         = 64,
   parameter int XLEN        = 32
) (
   input  logic                                          clock,
   input  logic                                          reset,
   input  logic                                          squash,
   input  logic [NUM_FU-1:0]                             fu_valid,
   input  logic [NUM_FU-1:0][$clog2(ROB_ENTRIES)-1:0]    fu_rob_idx,
   input  logic [NUM_FU-1:0][$clog2(PRF)-1:0]            fu_prn,
   input  logic [NUM_FU-1:0][XLEN-1:0]                   fu_value,
   input  logic [NUM_FU-1:0]                             fu_direction,
   input  logic [NUM_FU-1:0][XLEN-1:0]                   fu_target,
   output logic [NUM_FU-1:0]                             fu_ready,
   output logic [WAYS-1:0]                               cdb_valid,
   output logic [WAYS-1:0][$clog2(ROB_ENTRIES)-1:0]      cdb_rob_idx,
   output logic [WAYS-1:0][$clog2(PRF)-1:0]              cdb_prn,
   output logic [WAYS-1:0][XLEN-1:0]                     cdb_value,
   output logic [WAYS-1:0]                               cdb_direction,
   output logic [WAYS-1:0][XLEN-1:0]                     cdb_target,
   output logic [$clog2(NUM_FU):0]                       pending
);

   localparam int RW = $clog2(ROB_ENTRIES);
   localparam int PW = $clog2(PRF);
   localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
   localparam int CW = $clog2(NUM_FU) + 1;

   // Slot state and payload
   logic [NUM_FU-1:0]           r_held;
   logic [NUM_FU-1:0][RW-1:0]   r_rob_idx;
   logic [NUM_FU-1:0][PW-1:0]   r_prn;
   logic [NUM_FU-1:0][XLEN-1:0] r_value;
   logic [NUM_FU-1:0]           r_direction;
   logic [NUM_FU-1:0][XLEN-1:0] r_target;
   logic [IW-1:0]               r_rr_ptr;

   // Registered lanes
   logic [WAYS-1:0]           r_cdb_valid;
   logic [WAYS-1:0][RW-1:0]   r_cdb_rob_idx;
   logic [WAYS-1:0][PW-1:0]   r_cdb_prn;
   logic [WAYS-1:0][XLEN-1:0] r_cdb_value;
   logic [WAYS-1:0]           r_cdb_direction;
   logic [WAYS-1:0][XLEN-1:0] r_cdb_target;

   // Arbitration results
   logic [NUM_FU-1:0]         w_grant;
   logic [WAYS-1:0]           w_lane_vld;
   logic [WAYS-1:0][IW-1:0]   w_lane_src;
   logic [IW-1:0]             w_rr_next;
   logic [NUM_FU-1:0]         w_accept;
   logic [CW-1:0]             w_pending;
   logic                      w_kill;

   assign w_kill = reset | squash;

   // Rotating scan from r_rr_ptr; the n-th held slot found takes lane n.
   // The pointer follows the last slot granted so the next scan starts past it.
   // NOTE: every combinational output gets a default before the loop; a path
   // that leaves a signal unassigned would otherwise infer a latch.
   always_comb begin
      int n;
      int idx;
      w_grant    = '0;
      w_lane_vld = '0;
      w_lane_src = '0;
      w_rr_next  = r_rr_ptr;
      n          = 0;
      idx        = 0;
      for (int j = 0; j < NUM_FU; j++) begin
         idx = int'(r_rr_ptr) + j;
         if (idx >= NUM_FU) idx = idx - NUM_FU;
         if (r_held[idx] && (n < WAYS)) begin
            w_grant[idx]  = 1'b1;
            w_lane_vld[n] = 1'b1;
            w_lane_src[n] = IW'(idx);
            w_rr_next     = (idx + 1 == NUM_FU) ? '0 : IW'(idx + 1);
            n             = n + 1;
         end
      end
   end

   // A slot being broadcast this cycle can be refilled at the same edge.
   assign fu_ready = {NUM_FU{~w_kill}} & (~r_held | w_grant);
   assign w_accept = fu_valid & fu_ready;

   always_comb begin
      w_pending = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         w_pending = w_pending + CW'(r_held[i]);
      end
   end
   assign pending = w_pending;

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register sees pre-edge values; blocking '=' is reserved for always_comb.
   always_ff @(posedge clock) begin
      if (w_kill) begin
         r_held          <= '0;
         r_rr_ptr        <= '0;
         r_cdb_valid     <= '0;
         r_cdb_rob_idx   <= '0;
         r_cdb_prn       <= '0;
         r_cdb_value     <= '0;
         r_cdb_direction <= '0;
         r_cdb_target    <= '0;
      end else begin
         r_held <= (r_held & ~w_grant) | w_accept;
         if (|w_grant) r_rr_ptr <= w_rr_next;
         for (int k = 0; k < WAYS; k++) begin
            r_cdb_valid[k]     <= w_lane_vld[k];
            r_cdb_rob_idx[k]   <= w_lane_vld[k] ? r_rob_idx[w_lane_src[k]]   : '0;
            r_cdb_prn[k]       <= w_lane_vld[k] ? r_prn[w_lane_src[k]]       : '0;
            r_cdb_value[k]     <= w_lane_vld[k] ? r_value[w_lane_src[k]]     : '0;
            r_cdb_direction[k] <= w_lane_vld[k] & r_direction[w_lane_src[k]];
            r_cdb_target[k]    <= w_lane_vld[k] ? r_target[w_lane_src[k]]    : '0;
         end
      end
   end

   // NOTE: slot payload has no reset; it is only ever read while its held bit
   // is set, and held is cleared by reset.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (w_accept[i]) begin
            r_rob_idx[i]   <= fu_rob_idx[i];
            r_prn[i]       <= fu_prn[i];
            r_value[i]     <= fu_value[i];
            r_direction[i] <= fu_direction[i];
            r_target[i]    <= fu_target[i];
         end
      end
   end

   assign cdb_valid     = r_cdb_valid;
   assign cdb_rob_idx   = r_cdb_rob_idx;
   assign cdb_prn       = r_cdb_prn;
   assign cdb_value     = r_cdb_value;
   assign cdb_direction = r_cdb_direction;
   assign cdb_target    = r_cdb_target;

endmodule
